ram_port_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the 64 x 8 single-port RAM, which has a synchronous write and an asynchronous read. It grants the RAM's only port to one requester at a time and drives the RAM's `data_in`, `addr` and `mode` pins. It captures read data from the RAM's asynchronous output into a per-requester register and returns a one-cycle acknowledge. It sits between two client blocks, A and B, and one RAM instance.

---
 rtl/ram_port_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and sequencer granting a single-port 64x8 RAM to two
// requesters; every transaction runs IDLE -> ACCESS -> ACK.
module ram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_mode,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last;
    logic              owner;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] a_rd_q;
    logic [DATA_W-1:0] b_rd_q;
    logic              any_req;
    logic              grant_b;

    // last = 1 means A was served last... inverted: last = 0 -> A served last, B wins a tie
    always_comb begin
        any_req = a_req | b_req;
        grant_b = b_req & (~a_req | ~last);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last      <= 1'b1;
            owner     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            a_rd_q    <= '0;
            b_rd_q    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner     <= grant_b;
                cmd_we    <= grant_b ? b_we    : a_we;
                cmd_addr  <= grant_b ? b_addr  : a_addr;
                cmd_wdata <= grant_b ? b_wdata : a_wdata;
            end
            if (state == ACCESS) begin
                last <= owner;
                if (!cmd_we) begin
                    if (owner) b_rd_q <= ram_data_out;
                    else       a_rd_q <= ram_data_out;
                end
            end
        end
    end

    // Write strobe is gated with rst_n so a reset in ACCESS aborts the write.
    always_comb begin
        ram_mode    = rst_n & (state == ACCESS) & cmd_we;
        ram_addr    = cmd_addr;
        ram_data_in = cmd_wdata;
        a_ack       = (state == ACK) & ~owner;
        b_ack       = (state == ACK) & owner;
        a_rdata     = a_rd_q;
        b_rdata     = b_rd_q;
        busy        = (state != IDLE);
    end

endmodule
